// File: rtl/qeciphy_pkg.sv
// Shared types and constants for the QECiPHY receive path.
// Holds the comma symbol, aligner state encoding and lane index type.
package qeciphy_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;

   typedef logic [1:0] lane_t;

   typedef enum logic [2:0] {
      StSearch,
      StSlide,
      StSlideWait,
      StVerify,
      StLocked
   } aligner_state_e;

   // A comma only counts when the lane decoded without any code error.
   function automatic logic is_clean_comma(input logic [7:0] data,
                                           input logic       charisk,
                                           input logic       disperr,
                                           input logic       notintable);
      return charisk & (data == K28_5) & ~disperr & ~notintable;
   endfunction

endpackage

// File: rtl/qeciphy_rx_byte_rotator.sv
// Byte-lane rotator: registers the previous RX word and splices it with the current one
// so the selected lane becomes lane 0 of the registered output.
module qeciphy_rx_byte_rotator
   import qeciphy_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] data_i,
   input  logic [3:0]  charisk_i,
   input  lane_t       lane_i,
   output logic [31:0] data_o,
   output logic [3:0]  charisk_o
);

   logic [31:0] prev_data_q;
   logic [3:0]  prev_k_q;
   logic [31:0] data_q, data_d;
   logic [3:0]  k_q, k_d;

   // Output lane j takes stream byte (lane + j) of the {current, previous} byte stream.
   always_comb begin
      data_d = prev_data_q;
      k_d    = prev_k_q;
      unique case (lane_i)
         2'd0: begin
            data_d = prev_data_q;
            k_d    = prev_k_q;
         end
         2'd1: begin
            data_d = {data_i[7:0], prev_data_q[31:8]};
            k_d    = {charisk_i[0], prev_k_q[3:1]};
         end
         2'd2: begin
            data_d = {data_i[15:0], prev_data_q[31:16]};
            k_d    = {charisk_i[1:0], prev_k_q[3:2]};
         end
         2'd3: begin
            data_d = {data_i[23:0], prev_data_q[31:24]};
            k_d    = {charisk_i[2:0], prev_k_q[3]};
         end
         default: begin
            data_d = prev_data_q;
            k_d    = prev_k_q;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_data_q <= '0;
         prev_k_q    <= '0;
         data_q      <= '0;
         k_q         <= '0;
      end else begin
         prev_data_q <= data_i;
         prev_k_q    <= charisk_i;
         data_q      <= data_d;
         k_q         <= k_d;
      end
   end

   assign data_o    = data_q;
   assign charisk_o = k_q;

endmodule

// File: rtl/qeciphy_rx_word_aligner.sv
// RX word aligner: slides the transceiver until a K28.5 comma decodes cleanly, then locks
// onto its lane and presents a byte-rotated, qualified word stream to the link layer.
module qeciphy_rx_word_aligner
   import qeciphy_pkg::*;
#(
   parameter int unsigned SEARCH_TIMEOUT = 256,
   parameter int unsigned SLIDE_GUARD    = 32,
   parameter int unsigned LOCK_COUNT     = 8,
   parameter int unsigned UNLOCK_ERRORS  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] rx_data_in,
   input  logic [3:0]  rx_charisk_in,
   input  logic [3:0]  rx_disperr_in,
   input  logic [3:0]  rx_notintable_in,
   input  logic        rxsliderdy_in,
   output logic        rxslide_out,
   output logic [31:0] aligned_data_out,
   output logic [3:0]  aligned_charisk_out,
   output logic        aligned_valid_out,
   output logic        aligned_out,
   output logic [7:0]  slide_count_out
);

   localparam int unsigned TimerW = $clog2(SEARCH_TIMEOUT + 1);
   localparam int unsigned GuardW = $clog2(SLIDE_GUARD + 1);

   aligner_state_e state_q, state_d;

   logic [TimerW-1:0] timer_q, timer_d;
   logic [GuardW-1:0] guard_q, guard_d;
   logic              seen_q, seen_d;
   logic [7:0]        match_q, match_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   lane_t             lane_q, lane_d;
   logic [7:0]        slide_cnt_q, slide_cnt_d;

   logic rxslide_q, rxslide_d;
   logic aligned_q, aligned_d;
   logic valid_q, valid_d;

   logic [3:0] comma_lanes;
   lane_t      first_lane;
   logic       any_comma;
   logic       lane_comma;
   logic       code_err;
   logic       timeout;
   logic       guard_done;
   logic       lock_reached;
   logic       unlock_reached;

   // Lowest-indexed clean comma wins when several lanes carry one.
   always_comb begin
      comma_lanes = '0;
      first_lane  = '0;
      for (int i = 0; i < 4; i++) begin
         comma_lanes[i] = is_clean_comma(rx_data_in[8*i +: 8], rx_charisk_in[i],
                                         rx_disperr_in[i], rx_notintable_in[i]);
      end
      for (int i = 3; i >= 0; i--) begin
         if (comma_lanes[i]) first_lane = lane_t'(i);
      end
   end

   assign any_comma      = |comma_lanes;
   assign lane_comma     = comma_lanes[lane_q];
   assign code_err       = |(rx_disperr_in | rx_notintable_in);
   assign timeout        = (32'(timer_q) + 32'd1 >= SEARCH_TIMEOUT);
   assign guard_done     = (32'(guard_q) + 32'd1 >= SLIDE_GUARD) && (seen_q || rxsliderdy_in);
   assign lock_reached   = (32'(match_q) + 32'd1 >= LOCK_COUNT);
   assign unlock_reached = (32'(err_cnt_q) + 32'd1 >= UNLOCK_ERRORS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StSearch;
      end else begin
         state_q <= state_d;
      end
   end

   // Errors take priority over commas in every state that reacts to both.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StSearch: begin
            if (code_err) begin
               state_d = StSlide;
            end else if (any_comma) begin
               state_d = StVerify;
            end else if (timeout) begin
               state_d = StSlide;
            end
         end
         StSlide: begin
            state_d = StSlideWait;
         end
         StSlideWait: begin
            if (guard_done) state_d = StSearch;
         end
         StVerify: begin
            if (code_err) begin
               state_d = StSlide;
            end else if (lane_comma) begin
               if (lock_reached) state_d = StLocked;
            end else if (any_comma) begin
               state_d = StSearch;
            end
         end
         StLocked: begin
            if (code_err) begin
               if (unlock_reached) state_d = StSearch;
            end else if (!lane_comma && any_comma) begin
               state_d = StSearch;
            end
         end
         default: state_d = StSearch;
      endcase
   end

   always_comb begin
      timer_d     = '0;
      guard_d     = '0;
      seen_d      = 1'b0;
      match_d     = match_q;
      err_cnt_d   = '0;
      lane_d      = lane_q;
      slide_cnt_d = slide_cnt_q;
      case (state_q)
         StSearch: begin
            timer_d = timer_q + TimerW'(1);
            if (!code_err && any_comma) begin
               lane_d  = first_lane;
               match_d = 8'd1;
            end
         end
         StSlide: begin
            if (slide_cnt_q != 8'hFF) slide_cnt_d = slide_cnt_q + 8'd1;
         end
         StSlideWait: begin
            guard_d = guard_q;
            if (32'(guard_q) < SLIDE_GUARD) guard_d = guard_q + GuardW'(1);
            seen_d = seen_q | rxsliderdy_in;
         end
         StVerify: begin
            if (!code_err && lane_comma) match_d = match_q + 8'd1;
         end
         StLocked: begin
            err_cnt_d = err_cnt_q;
            if (code_err) begin
               err_cnt_d = err_cnt_q + 8'd1;
            end else if (lane_comma) begin
               err_cnt_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q     <= '0;
         guard_q     <= '0;
         seen_q      <= 1'b0;
         match_q     <= '0;
         err_cnt_q   <= '0;
         lane_q      <= '0;
         slide_cnt_q <= '0;
      end else begin
         timer_q     <= timer_d;
         guard_q     <= guard_d;
         seen_q      <= seen_d;
         match_q     <= match_d;
         err_cnt_q   <= err_cnt_d;
         lane_q      <= lane_d;
         slide_cnt_q <= slide_cnt_d;
      end
   end

   // Valid trails lock by one cycle so it lines up with the rotator's extra register.
   always_comb begin
      rxslide_d = (state_q == StSlide);
      aligned_d = (state_q == StLocked);
      valid_d   = aligned_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxslide_q <= 1'b0;
         aligned_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         rxslide_q <= rxslide_d;
         aligned_q <= aligned_d;
         valid_q   <= valid_d;
      end
   end

   qeciphy_rx_byte_rotator u_rotator (
      .clk_i     (clk),
      .rst_i     (rst),
      .data_i    (rx_data_in),
      .charisk_i (rx_charisk_in),
      .lane_i    (lane_q),
      .data_o    (aligned_data_out),
      .charisk_o (aligned_charisk_out)
   );

   assign rxslide_out       = rxslide_q;
   assign aligned_out       = aligned_q;
   assign aligned_valid_out = valid_q;
   assign slide_count_out   = slide_cnt_q;

endmodule
